// File: rtl/i2s_rx.sv
// I2S receiver: samples bclk/lrclk/sdata through 2-flop synchronizers,
// deframes left/right words MSB first and queues {left, right} frames.
// Ports: clk_i, reset_i (async, active-high), bclk_i, lrclk_i, sdata_i,
//        ready_i, valid_o, data_l_o, data_r_o, overflow_o, frame_err_o,
//        overflow_cnt_o (only when I2S_RX_OVERFLOW_CNT_EN is defined).
module i2s_rx #(
    parameter int width_p = 16,
    parameter int depth_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               bclk_i,
    input  logic               lrclk_i,
    input  logic               sdata_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_l_o,
    output logic [width_p-1:0] data_r_o,
    output logic               overflow_o,
    output logic               frame_err_o
`ifdef I2S_RX_OVERFLOW_CNT_EN
    ,
    output logic [15:0]        overflow_cnt_o
`endif
);

    localparam int aw_lp = $clog2(depth_p);
    localparam int cw_lp = $clog2(width_p + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        DISCARD
    } state_t;

    logic [1:0] bclk_sync;
    logic [1:0] lrclk_sync;
    logic [1:0] sdata_sync;
    logic       bclk_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            sdata_sync <= '0;
            bclk_q     <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[0], bclk_i};
            lrclk_sync <= {lrclk_sync[0], lrclk_i};
            sdata_sync <= {sdata_sync[0], sdata_i};
            bclk_q     <= bclk_sync[1];
        end
    end

    logic sample;
    logic lr;
    logic sd;
    logic lr_q;
    logic lr_chg;

    assign sample = bclk_sync[1] & ~bclk_q;
    assign lr     = lrclk_sync[1];
    assign sd     = sdata_sync[1];
    assign lr_chg = sample && (lr != lr_q);

    state_t             state_q;
    logic               chan_q;
    logic [cw_lp-1:0]   cnt_q;
    logic [width_p-1:0] shift_q;
    logic [width_p-1:0] left_q;
    logic               frame_err_q;

    logic [width_p-1:0] shift_next;
    logic [width_p-1:0] word;
    logic [cw_lp-1:0]   fill;
    logic               last_bit;
    logic               done;
    logic               push;

    // The bit seen at an lrclk change is the LSB of the word just ending
    // (I2S one-bit delay), so a short slot still ends with a captured bit.
    assign shift_next = {shift_q[width_p-2:0], sd};
    assign last_bit   = (cnt_q == cw_lp'(width_p - 1));
    assign fill       = cw_lp'(width_p - 1) - cnt_q;
    assign word       = shift_next << fill;
    assign done       = sample && (state_q == SHIFT) && (lr_chg || last_bit);
    assign push       = done && chan_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            lr_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (sample) begin
                lr_q <= lr;
            end
            unique case (state_q)
                IDLE: begin
                    if (lr_chg && !lr) begin
                        state_q <= DELAY;
                        chan_q  <= 1'b0;
                    end
                end
                // The delay bit was consumed at the change point; the
                // MSB arrives at the next sample point.
                DELAY: begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    shift_q <= '0;
                end
                SHIFT: begin
                    if (sample) begin
                        shift_q <= shift_next;
                        cnt_q   <= cnt_q + 1'b1;
                        if (done && !chan_q) begin
                            left_q <= word;
                        end
                        if (lr_chg) begin
                            frame_err_q <= !last_bit;
                            state_q     <= DELAY;
                            chan_q      <= lr;
                        end else if (last_bit) begin
                            state_q <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (lr_chg) begin
                        state_q <= DELAY;
                        chan_q  <= lr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [2*width_p-1:0] mem_q [depth_p];
    logic [aw_lp:0]       wr_q;
    logic [aw_lp:0]       rd_q;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic                 overflow_q;

    assign full    = (wr_q[aw_lp] != rd_q[aw_lp]) &&
                     (wr_q[aw_lp-1:0] == rd_q[aw_lp-1:0]);
    assign valid_o = (wr_q != rd_q);
    assign pop     = valid_o && ready_i;
    assign wr_en   = push && (!full || pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            overflow_q <= push && full && !pop;
            if (wr_en) begin
                mem_q[wr_q[aw_lp-1:0]] <= {left_q, word};
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign data_l_o    = mem_q[rd_q[aw_lp-1:0]][2*width_p-1:width_p];
    assign data_r_o    = mem_q[rd_q[aw_lp-1:0]][width_p-1:0];
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;

`ifdef I2S_RX_OVERFLOW_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_cnt_q <= '0;
        end else if (overflow_q && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign overflow_cnt_o = ovf_cnt_q;
`endif

endmodule
